// File: rtl/dsp_pkg.sv
// Shared types for the DSP coprocessor and the pipeline decoder that issues its commands.
// The op encoding must stay identical to the decoder's copy.
package dsp_pkg;

    typedef enum logic [1:0] {
        MUL  = 2'b00,
        MAC  = 2'b01,
        MULH = 2'b10,
        CLR  = 2'b11
    } dsp_op_t;

    // The S_ prefix keeps state names apart from the op name MUL.
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIX,
        S_DONE
    } dsp_state_t;

endpackage

// File: rtl/dsp_if.sv
// Command/result bundle between the pipeline execute stage and the DSP coprocessor.
// The pipeline is the master; it holds a command until busy drops.
interface dsp_if
    import dsp_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start_dsp;
    dsp_op_t          op_dsp;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dsp_result;

    modport master (
        output start_dsp, op_dsp, op_a, op_b,
        input  busy, done, dsp_result
    );

    modport slave (
        input  start_dsp, op_dsp, op_a, op_b,
        output busy, done, dsp_result
    );
endinterface

// File: rtl/dsp_seq_mult.sv
// Unsigned iterative shift-add multiplier, one partial-product step per cycle.
// Latency: WIDTH steps after load; last is high while the final step is being taken.
// No backpressure: the owner decides when to load and step.
module dsp_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;

    // Multiplier sits in the low half and shifts out as the product grows into the top.
    assign sum  = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);
    assign last = (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            product <= '0;
            cnt     <= '0;
        end else if (load) begin
            mcand   <= a_mag;
            product <= {{WIDTH{1'b0}}, b_mag};
            cnt     <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            product <= {sum, product[WIDTH-1:1]};
            if (!last) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/dsp_coproc.sv
// Signed MUL / MULH / MAC / CLR coprocessor with a persistent accumulator.
// Latency: done WIDTH+1 edges after accept (CLR: right after accept); busy for WIDTH+2 edges.
// Backpressure: start_dsp is ignored while busy; the pipeline holds the command until busy=0.
module dsp_coproc
    import dsp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    dsp_if.slave  bus
);
    dsp_state_t         state, state_nxt;
    dsp_op_t            op_q;
    logic               sign_q;
    logic               accept;
    logic               load;
    logic               step;
    logic               last;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   result_q;
    logic [2*WIDTH-1:0] mag_prod;
    logic [2*WIDTH-1:0] prod;

    assign accept = (state == S_IDLE) && bus.start_dsp;

    // Negating -2^(WIDTH-1) yields 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign a_mag = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    assign b_mag = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    assign prod  = sign_q ? -mag_prod : mag_prod;

    dsp_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .product (mag_prod),
        .last    (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_dsp) begin
                    if (bus.op_dsp == CLR) begin
                        state_nxt = S_DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = S_MUL;
                    end
                end
            end
            S_MUL: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= MUL;
            sign_q   <= 1'b0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.op_dsp;
                sign_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                if (bus.op_dsp == CLR) begin
                    acc      <= '0;
                    result_q <= '0;
                end
            end
            if (state == S_FIX) begin
                case (op_q)
                    MUL:  result_q <= prod[WIDTH-1:0];
                    MULH: result_q <= prod[2*WIDTH-1:WIDTH];
                    MAC: begin
                        acc      <= acc + prod[WIDTH-1:0];
                        result_q <= acc + prod[WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.dsp_result = result_q;
endmodule

// File: tb/tb_dsp_coproc.sv
// Randomized and directed bench for dsp_coproc against a plain-arithmetic signed model.
module tb_dsp_coproc;
    import dsp_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dsp_if #(.WIDTH(W)) bus();

    dsp_coproc #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] acc_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full 64-bit signed product, then pick the part each op asks for.
    task automatic model(input dsp_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res);
        longint sa, sb, pv;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pv = sa * sb;
        p  = pv;
        res = '0;
        case (op)
            MUL:  res = p[31:0];
            MULH: res = p[63:32];
            MAC: begin
                acc_m = acc_m + p[31:0];
                res   = acc_m;
            end
            default: begin
                acc_m = '0;
                res   = '0;
            end
        endcase
    endtask

    task automatic run_op(input dsp_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag, output logic [W-1:0] res);
        logic [W-1:0] exp_res;
        int k;
        k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus.start_dsp = 1'b1;
        bus.op_dsp    = op;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start_dsp = 1'b0;
        chk({tag, " busy_after_accept"}, bus.busy, 1);
        model(op, a, b, exp_res);
        k = 0;
        while (!bus.done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " latency"}, k, (op == CLR) ? 0 : W + 1);
        chk({tag, " result"}, bus.dsp_result, exp_res);
        res = bus.dsp_result;
        @(posedge clk);
        #1;
        chk({tag, " busy_done_after"}, {bus.busy, bus.done}, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] exp_res;
        int dones;

        reset         = 1'b1;
        bus.start_dsp = 1'b0;
        bus.op_dsp    = MUL;
        bus.op_a      = '0;
        bus.op_b      = '0;
        acc_m         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset result", bus.dsp_result, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(MUL, 32'd7, 32'hFFFF_FFFD, "mul 7x-3", r);
        chk("mul 7x-3 const", r, 32'hFFFF_FFEB);
        run_op(MULH, 32'h8000_0000, 32'h8000_0000, "mulh minsq", r);
        chk("mulh minsq const", r, 32'h4000_0000);
        run_op(MULH, 32'hFFFF_FFFF, 32'd1, "mulh -1x1", r);
        chk("mulh -1x1 const", r, 32'hFFFF_FFFF);

        run_op(CLR, 0, 0, "clr1", r);
        run_op(MAC, 32'd3, 32'd4, "mac 3x4", r);
        chk("mac 3x4 const", r, 32'h0000_000C);
        run_op(MAC, 32'd5, 32'd6, "mac 5x6", r);
        chk("mac 5x6 const", r, 32'h0000_002A);
        run_op(CLR, 0, 0, "clr2", r);
        chk("clr2 const", r, 0);

        // Commands arriving mid-operation and in the DONE cycle must be dropped.
        run_op(MAC, 32'd5, 32'd5, "mac seed", r);
        @(negedge clk);
        bus.start_dsp = 1'b1;
        bus.op_dsp    = MUL;
        bus.op_a      = 32'd2;
        bus.op_b      = 32'd3;
        @(posedge clk);
        #1;
        bus.start_dsp = 1'b0;
        model(MUL, 32'd2, 32'd3, exp_res);
        dones = 0;
        for (int e = 1; e <= W + 4; e++) begin
            if (e == 5 || e == W + 2) begin
                bus.start_dsp = 1'b1;
                bus.op_dsp    = MAC;
                bus.op_a      = 32'd9;
                bus.op_b      = 32'd9;
            end
            @(posedge clk);
            #1;
            bus.start_dsp = 1'b0;
            if (bus.done) dones++;
            if (e == W + 1) chk("ignore result", bus.dsp_result, exp_res);
            if (e == W + 3) chk("ignore busy", bus.busy, 0);
        end
        chk("ignore done count", dones, 1);
        run_op(MAC, 32'd1, 32'd0, "ignore acc", r);

        // Reset in the middle of a MAC abandons it and clears the accumulator.
        @(negedge clk);
        bus.start_dsp = 1'b1;
        bus.op_dsp    = MAC;
        bus.op_a      = 32'd100;
        bus.op_b      = 32'd100;
        @(posedge clk);
        #1;
        bus.start_dsp = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        acc_m = '0;
        #1;
        chk("midreset outputs", {bus.busy, bus.done, bus.dsp_result}, 0);
        dones = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("midreset no done", dones, 0);
        run_op(MAC, 32'd2, 32'd2, "post reset mac", r);
        chk("post reset mac const", r, 32'd4);

        run_op(CLR, 0, 0, "clr3", r);
        run_op(MAC, 32'hFFFF_FFFF, 32'd1, "mac to -1", r);
        chk("mac to -1 const", r, 32'hFFFF_FFFF);
        run_op(MAC, 32'd1, 32'd1, "mac wrap", r);
        chk("mac wrap const", r, 32'h0000_0000);

        for (int i = 0; i < 40; i++) begin
            run_op(dsp_op_t'($urandom_range(0, 3)), pick(), pick(), $sformatf("rand%0d", i), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
